// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC, 2-entry {data,pc} FIFO, one in-flight read, redirect flush.
// Define FETCH_DBG_PORT_EN to add a debug read port sharing pm_addr.
`ifndef PROGRAM_DATA_MAX_LENGTH
`define PROGRAM_DATA_MAX_LENGTH 8
`endif
`ifndef PROGRAM_DATA_SIZE
`define PROGRAM_DATA_SIZE 16
`endif

module instruction_fetch_unit #(
   parameter int                ADDR_W   = `PROGRAM_DATA_MAX_LENGTH,
   parameter int                DATA_W   = `PROGRAM_DATA_SIZE,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [ADDR_W-1:0] pm_addr,
   input  logic [DATA_W-1:0] pm_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_DBG_PORT_EN
   ,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_data
`endif
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_ifpc;
   logic              r_inflight;
   logic [1:0]        r_count;
   logic              r_head;
   logic [DATA_W-1:0] r_data [2];
   logic [ADDR_W-1:0] r_dpc  [2];

   logic              w_grant;
   logic              w_empty;
   logic              w_pop;
   logic              w_pop_q;
   logic              w_push_q;
   logic              w_issue;
   logic [1:0]        w_occ;
   logic              w_wr_idx;

`ifdef FETCH_DBG_PORT_EN
   logic r_dbg_pend;

   assign w_grant  = dbg_req;
   assign pm_addr  = dbg_req ? dbg_addr : r_pc;
   assign dbg_ack  = r_dbg_pend;
   assign dbg_data = r_dbg_pend ? pm_data : '0;

   // Independent of redirect so a pending ack always completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_dbg_pend <= 1'b0;
      else     r_dbg_pend <= dbg_req;
   end
`else
   assign w_grant = 1'b0;
   assign pm_addr = r_pc;
`endif

   // Returning read data is visible as the head while the FIFO is empty
   assign w_empty     = (r_count == 2'd0);
   assign instr_valid = !w_empty || r_inflight;
   assign w_pop       = instr_valid && instr_ready;
   assign w_pop_q     = w_pop && !w_empty;
   assign w_push_q    = r_inflight && !(w_pop && w_empty);
   assign w_occ       = r_count + {1'b0, r_inflight};
   assign w_wr_idx    = r_head ^ r_count[0];

   assign w_issue = enable && !redirect_valid && !w_grant &&
                    ((w_occ - {1'b0, w_pop}) < 2'd2);

   always_comb begin
      instr    = '0;
      instr_pc = '0;
      if (!w_empty) begin
         instr    = r_data[r_head];
         instr_pc = r_dpc[r_head];
      end else if (r_inflight) begin
         instr    = pm_data;
         instr_pc = r_ifpc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_ifpc     <= '0;
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
         r_head     <= 1'b0;
      end else if (redirect_valid) begin
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
         r_head     <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc   <= r_pc + ADDR_W'(1);
            r_ifpc <= r_pc;
         end
         if (w_pop_q) r_head <= ~r_head;
         r_count <= r_count + {1'b0, w_push_q} - {1'b0, w_pop_q};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_q && !redirect_valid) begin
         r_data[w_wr_idx] <= pm_data;
         r_dpc[w_wr_idx]  <= r_ifpc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, reset and
// randomized run against a queue-based reference model.
module tb_instruction_fetch_unit;
   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          instr_ready = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [AW-1:0] pm_addr;
   logic [DW-1:0] pm_data = '0;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
`ifdef FETCH_DBG_PORT_EN
   logic          dbg_req = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic          dbg_ack;
   logic [DW-1:0] dbg_data;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   instruction_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .pm_addr       (pm_addr),
      .pm_data       (pm_data),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
`ifdef FETCH_DBG_PORT_EN
      ,
      .dbg_req       (dbg_req),
      .dbg_addr      (dbg_addr),
      .dbg_ack       (dbg_ack),
      .dbg_data      (dbg_data)
`endif
   );

   function automatic logic [DW-1:0] memv(input logic [AW-1:0] a);
      return 16'h0100 + DW'(a);
   endfunction

   always #5 clk = ~clk;

   always @(posedge clk) pm_data <= memv(pm_addr);

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          en;
      logic          rdy;
      logic          rd;
      logic [AW-1:0] rpc;
      logic          ev;
      logic [AW-1:0] epc;
      logic [AW-1:0] eaddr;
   } vec_t;

   vec_t tbl [26];
   int   nv = 0;

   task automatic v(input logic en, input logic rdy, input logic rd,
                    input logic [AW-1:0] rpc, input logic ev,
                    input logic [AW-1:0] epc, input logic [AW-1:0] eaddr);
      tbl[nv] = '{en, rdy, rd, rpc, ev, epc, eaddr};
      nv++;
   endtask

   logic [AW-1:0] q [$];
   logic          pend_v;
   logic [AW-1:0] pend_pc;
   logic [AW-1:0] mpc;
   logic          ev;
   logic          grant;
   logic          issue;
   logic          dpend;
   logic [AW-1:0] daddr_q;
   logic [AW-1:0] exp_addr;

   initial begin
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   8'd0);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd0,   8'd1);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd1,   8'd2);
      v(1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   8'd3);
      v(1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   8'd4);
      v(1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   8'd4);
      v(1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   8'd4);
      v(1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   8'd4);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd2,   8'd4);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd3,   8'd5);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd4,   8'd6);
      v(1'b1, 1'b0, 1'b1, 8'd16,  1'b1, 8'd5,   8'd7);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   8'd16);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd16,  8'd17);
      v(1'b1, 1'b1, 1'b1, 8'd254, 1'b1, 8'd17,  8'd18);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   8'd254);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd254, 8'd255);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd255, 8'd0);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd0,   8'd1);
      v(1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 8'd1,   8'd2);
      v(1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   8'd2);
      v(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd0,   8'd2);
      v(1'b1, 1'b1, 1'b1, 8'd40,  1'b1, 8'd2,   8'd3);
      v(1'b1, 1'b1, 1'b1, 8'd60,  1'b0, 8'd0,   8'd40);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   8'd60);
      v(1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd60,  8'd61);

      // Outputs held clear while in reset
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
      chk("rst_addr", 32'(pm_addr), 32'd0);

      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         if (i == 0) rst = 1'b0;
         enable         = tbl[i].en;
         instr_ready    = tbl[i].rdy;
         redirect_valid = tbl[i].rd;
         redirect_pc    = tbl[i].rpc;
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_addr", i), 32'(pm_addr), 32'(tbl[i].eaddr));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(tbl[i].epc));
            chk($sformatf("vec%0d_instr", i), 32'(instr),
                32'(memv(tbl[i].epc)));
         end
      end

      // Mid-stream asynchronous reset, then restart at address 0
      @(negedge clk);
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      #1;
      chk("pre_rst_valid", 32'(instr_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_instr", 32'(instr), 32'd0);
      chk("mid_rst_pc", 32'(instr_pc), 32'd0);
      chk("mid_rst_addr", 32'(pm_addr), 32'd0);
      @(negedge clk);
      rst         = 1'b0;
      instr_ready = 1'b1;
      #1;
      chk("rel_valid", 32'(instr_valid), 32'd0);
      chk("rel_addr", 32'(pm_addr), 32'd0);
      @(negedge clk);
      #1;
      chk("restart_valid", 32'(instr_valid), 32'd1);
      chk("restart_pc", 32'(instr_pc), 32'd0);
      chk("restart_instr", 32'(instr), 32'h100);

      // Randomized run against the queue model
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      q.delete();
      pend_v  = 1'b0;
      pend_pc = '0;
      mpc     = '0;
      dpend   = 1'b0;
      daddr_q = '0;
      for (int i = 0; i < 3000; i++) begin
         if (i != 0) @(negedge clk);
         rst            = 1'b0;
         enable         = ($urandom_range(0, 9) != 0);
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = AW'($urandom);
         grant          = 1'b0;
`ifdef FETCH_DBG_PORT_EN
         dbg_req  = ($urandom_range(0, 15) == 0);
         dbg_addr = AW'($urandom);
         grant    = dbg_req;
`endif
         if (pend_v) q.push_back(pend_pc);
         #1;
         ev = (q.size() != 0);
         chk("rnd_valid", 32'(instr_valid), 32'(ev));
         if (ev) begin
            chk("rnd_pc", 32'(instr_pc), 32'(q[0]));
            chk("rnd_instr", 32'(instr), 32'(memv(q[0])));
         end
         exp_addr = mpc;
`ifdef FETCH_DBG_PORT_EN
         if (dbg_req) exp_addr = dbg_addr;
         chk("rnd_dbg_ack", 32'(dbg_ack), 32'(dpend));
         if (dpend) chk("rnd_dbg_data", 32'(dbg_data), 32'(memv(daddr_q)));
         daddr_q = dbg_addr;
`endif
         chk("rnd_addr", 32'(pm_addr), 32'(exp_addr));
         if (ev && instr_ready) void'(q.pop_front());
         issue = enable && !redirect_valid && !grant && (q.size() < 2);
         dpend = grant;
         if (redirect_valid) begin
            q.delete();
            pend_v = 1'b0;
            mpc    = redirect_pc;
         end else begin
            pend_v  = issue;
            pend_pc = mpc;
            if (issue) mpc = mpc + 8'd1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
